// File: rtl/gigatron_pkg.sv
// Shared Gigatron definitions: GT1 loader state encoding, bus widths and
// the GT1 segment terminator byte.
package gigatron_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned OPT_W  = 4;
  localparam int unsigned CNT_W  = 9;

  localparam logic [DATA_W-1:0] GT1_TERMINATOR = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HI,
    ST_LO,
    ST_SIZE,
    ST_DATA,
    ST_EXEC_HI,
    ST_EXEC_LO,
    ST_FIN,
    ST_ERR
  } gt1_state_t;

  // A GT1 size byte of zero encodes a full 256-byte segment
  function automatic logic [CNT_W-1:0] seg_count(input logic [DATA_W-1:0] b);
    return (b == 8'h00) ? CNT_W'(256) : CNT_W'(b);
  endfunction

endpackage

// File: rtl/gt1_loader.sv
// GT1 image loader: parses a GT1 file from the option ROM and copies its
// segments into Gigatron RAM. Define GT1_LOADER_CHECKSUM_EN for a write checksum.
module gt1_loader
  import gigatron_pkg::*;
#(
  parameter int unsigned ROM_ARRAY_SIZE = 32767,
  parameter logic [3:0]  OPTION_DEFAULT = 4'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  option_in,
  output logic [3:0]  option_select,
  output logic [15:0] rom_address,
  input  logic [7:0]  rom_data,
  input  logic        ram_ready,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] exec_addr
`ifdef GT1_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]  checksum
`endif
);

  gt1_state_t         r_state;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [DATA_W-1:0]  r_page;
  logic [DATA_W-1:0]  r_low;
  logic [CNT_W-1:0]   r_count;
  logic               r_first;

  logic               w_want;
  logic               w_past_end;
  logic               w_take;
  logic               w_fault;

  // States that want a ROM byte this cycle; DATA only when the RAM bus is ours
  always_comb begin
    w_want = 1'b0;
    case (r_state)
      ST_HI, ST_LO, ST_SIZE, ST_EXEC_HI, ST_EXEC_LO: w_want = 1'b1;
      ST_DATA:                                       w_want = ram_ready;
      default:                                       w_want = 1'b0;
    endcase
  end

  // The read pointer keeps one spare bit so running off the image is detectable
  assign w_past_end  = r_rd_ptr > ADDR_W'(ROM_ARRAY_SIZE);
  assign w_take      = w_want & ~w_past_end;
  assign w_fault     = w_want & w_past_end;
  assign rom_address = {1'b0, r_rd_ptr[ADDR_W-2:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_rd_ptr      <= '0;
      r_page        <= '0;
      r_low         <= '0;
      r_count       <= '0;
      r_first       <= 1'b0;
      option_select <= OPTION_DEFAULT;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      exec_addr     <= '0;
`ifdef GT1_LOADER_CHECKSUM_EN
      checksum      <= '0;
`endif
    end else begin
      ram_we <= 1'b0;
      if (w_take) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          option_select <= OPTION_DEFAULT;
          if (start) begin
            option_select <= option_in;
            r_rd_ptr      <= '0;
            r_first       <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            busy          <= 1'b1;
`ifdef GT1_LOADER_CHECKSUM_EN
            checksum      <= '0;
`endif
            r_state       <= ST_HI;
          end
        end

        // Only a terminator after the first segment ends the segment list
        ST_HI: begin
          if (w_fault) begin
            r_state <= ST_ERR;
          end else if (rom_data == GT1_TERMINATOR && !r_first) begin
            r_state <= ST_EXEC_HI;
          end else begin
            r_page  <= rom_data;
            r_first <= 1'b0;
            r_state <= ST_LO;
          end
        end

        ST_LO: begin
          if (w_fault) begin
            r_state <= ST_ERR;
          end else begin
            r_low   <= rom_data;
            r_state <= ST_SIZE;
          end
        end

        ST_SIZE: begin
          if (w_fault) begin
            r_state <= ST_ERR;
          end else begin
            r_count <= seg_count(rom_data);
            r_state <= ST_DATA;
          end
        end

        // Low address wraps inside the page; the page byte never carries
        ST_DATA: begin
          if (w_fault) begin
            r_state <= ST_ERR;
          end else if (w_take) begin
            ram_we    <= 1'b1;
            ram_addr  <= {r_page, r_low};
            ram_wdata <= rom_data;
`ifdef GT1_LOADER_CHECKSUM_EN
            checksum  <= checksum + rom_data;
`endif
            r_low     <= r_low + DATA_W'(1);
            r_count   <= r_count - CNT_W'(1);
            if (r_count == CNT_W'(1)) begin
              r_state <= ST_HI;
            end
          end
        end

        ST_EXEC_HI: begin
          if (w_fault) begin
            r_state <= ST_ERR;
          end else begin
            exec_addr[15:8] <= rom_data;
            r_state         <= ST_EXEC_LO;
          end
        end

        ST_EXEC_LO: begin
          if (w_fault) begin
            r_state <= ST_ERR;
          end else begin
            exec_addr[7:0] <= rom_data;
            r_state        <= ST_FIN;
          end
        end

        ST_FIN: begin
          done          <= 1'b1;
          busy          <= 1'b0;
          option_select <= OPTION_DEFAULT;
          r_state       <= ST_IDLE;
        end

        ST_ERR: begin
          error         <= 1'b1;
          busy          <= 1'b0;
          option_select <= OPTION_DEFAULT;
          r_state       <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
